// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises per-requester byte frames onto one UART
// transmit stream, prefixing each frame with a header byte 8'h80 | grant index.
module uart_frame_arbiter #(
  parameter int unsigned REQ_COUNT = 16,
  parameter int unsigned TIMEOUT   = 1024,
  localparam int unsigned IDX_W    = $clog2(REQ_COUNT)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [REQ_COUNT-1:0]   req_valid_i,
  input  logic [REQ_COUNT*8-1:0] req_data_i,
  input  logic [REQ_COUNT-1:0]   req_last_i,
  output logic [REQ_COUNT-1:0]   req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   abort_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, last_grant_q;
  logic [CNT_W-1:0]   stall_q;
  logic               abort_q;

  logic [7:0]         req_bytes [REQ_COUNT];
  logic               g_valid, g_last, pay_hs, frame_end, timeout;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  int unsigned        cand;

  for (genvar k = 0; k < int'(REQ_COUNT); k++) begin : g_bytes
    assign req_bytes[k] = req_data_i[8*k +: 8];
  end

  assign g_valid   = req_valid_i[grant_q];
  assign g_last    = req_last_i[grant_q];
  assign pay_hs    = (state_q == PAYLOAD) && g_valid && tx_ready_i;
  assign frame_end = pay_hs && g_last;
  assign timeout   = (state_q == PAYLOAD) && !g_valid && (stall_q == CNT_W'(TIMEOUT - 1));

  // Round-robin search starting just above the most recent grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      cand = 32'(last_grant_q) + 32'd1 + i;
      if (cand >= REQ_COUNT) cand = cand - REQ_COUNT;
      if (!win_found && req_valid_i[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = HEADER;
      HEADER:  if (tx_ready_i) state_d = PAYLOAD;
      PAYLOAD: if (frame_end || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping, stall counter and the abort pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      grant_q      <= '0;
      last_grant_q <= IDX_W'(REQ_COUNT - 1);
      stall_q      <= '0;
      abort_q      <= 1'b0;
    end else begin
      abort_q <= timeout;
      if (state_q == IDLE && win_found) grant_q <= win_idx;
      if (frame_end || timeout) last_grant_q <= grant_q;
      if (state_q != PAYLOAD || pay_hs || timeout) stall_q <= '0;
      else if (!g_valid)                         stall_q <= stall_q + CNT_W'(1);
    end
  end

  // Payload phase is a combinational pass-through from the granted requester.
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      HEADER: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h80 | 8'(grant_q);
      end
      PAYLOAD: begin
        tx_valid_o           = g_valid;
        tx_data_o            = req_bytes[grant_q];
        req_ready_o[grant_q] = tx_ready_i;
      end
      default: ;
    endcase
  end

  assign abort_o     = abort_q;
  assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Scoreboard bench for uart_frame_arbiter: per-requester byte sources feed the
// DUT and every transmitted byte is compared against a queue of expected bytes.
module tb_uart_frame_arbiter;

  localparam int unsigned N   = 16;
  localparam int unsigned TMO = 8;
  localparam int unsigned IW  = 4;

  logic           clk = 1'b0;
  logic           arst;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic           busy;
  logic [IW-1:0]  grant_idx;
  logic           abort;

  always #5 clk = ~clk;

  uart_frame_arbiter #(.REQ_COUNT(N), .TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .grant_idx_o (grant_idx),
    .abort_o     (abort)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] gap;
  } exp_t;

  exp_t         sb[$];
  logic [8:0]   src_mem [N][16];
  int           src_head [N];
  int           src_tail [N];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           last_hs_cyc = 0;
  int           abort_cnt = 0;
  int           abort_gap = 0;
  logic [N-1:0] allow_mask;
  logic [N-1:0] hs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = 8'(gap);
    sb.push_back(e);
  endtask

  task automatic enqueue(input int k, input logic [7:0] d, input logic last);
    src_mem[k][src_tail[k]] = {last, d};
    src_tail[k]++;
  endtask

  task automatic drive();
    for (int k = 0; k < int'(N); k++) begin
      if (src_head[k] < src_tail[k]) begin
        req_valid[k]        = 1'b1;
        req_data[k*8 +: 8]  = src_mem[k][src_head[k]][7:0];
        req_last[k]         = src_mem[k][src_head[k]][8];
      end else begin
        req_valid[k]        = 1'b0;
        req_data[k*8 +: 8]  = 8'h00;
        req_last[k]         = 1'b0;
      end
    end
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    hs = '0;
    if (!arst) begin
      check_eq("ready_mask", 32'(req_ready & ~allow_mask), 32'd0);
      if (abort) begin
        abort_cnt++;
        abort_gap = cyc - last_hs_cyc;
        check_eq("abort_busy", 32'(busy), 32'd0);
      end
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          check_eq("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check_eq("tx_byte", 32'(tx_data), 32'(e.data));
          if (e.gap != 0) check_eq("hs_gap", 32'(cyc - last_hs_cyc), 32'(e.gap));
        end
        last_hs_cyc = cyc;
      end
      hs = req_valid & req_ready;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < int'(N); k++) if (hs[k]) src_head[k]++;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_left", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    step();
    step();
    arst = 1'b0;
  endtask

  initial begin
    arst       = 1'b1;
    tx_ready   = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    allow_mask = '0;
    for (int k = 0; k < int'(N); k++) begin
      src_head[k] = 0;
      src_tail[k] = 0;
    end

    // Reset values before any clock edge
    #3;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_abort", 32'(abort), 32'd0);
    check_eq("rst_grant", 32'(grant_idx), 32'd0);
    step();
    step();
    arst = 1'b0;

    // Single frame from requester 3
    allow_mask = N'(1) << 3;
    tx_ready   = 1'b1;
    expect_byte(8'h83, 0);
    expect_byte(8'hAA, 1);
    expect_byte(8'hBB, 1);
    enqueue(3, 8'hAA, 1'b0);
    enqueue(3, 8'hBB, 1'b1);
    drive();
    drain(50);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    check_eq("t1_grant", 32'(grant_idx), 32'd3);

    // All requesters continuously requesting: full rotation then wrap
    do_reset();
    allow_mask = '1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < int'(N); k++) begin
        enqueue(k, 8'(k * 16 + r), 1'b1);
        expect_byte(8'h80 | 8'(k), (r == 0 && k == 0) ? 0 : 2);
        expect_byte(8'(k * 16 + r), 1);
      end
    end
    drive();
    drain(400);
    check_eq("t2_abort_cnt", 32'(abort_cnt), 32'd0);

    // Header held while transmitter stalls
    allow_mask = N'(1) << 7;
    tx_ready   = 1'b0;
    enqueue(7, 8'h55, 1'b1);
    drive();
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hdr_valid", 32'(tx_valid), 32'd1);
      check_eq("t3_hdr_data", 32'(tx_data), 32'h87);
      check_eq("t3_ready_zero", 32'(req_ready), 32'd0);
      step();
    end
    check_eq("t3_not_consumed", 32'(src_head[7]), 32'(src_tail[7] - 1));
    expect_byte(8'h87, 0);
    expect_byte(8'h55, 1);
    tx_ready = 1'b1;
    drain(20);

    // Stalled frame from requester 2 times out; requester 3 goes next
    allow_mask = (N'(1) << 2) | (N'(1) << 3);
    abort_cnt  = 0;
    expect_byte(8'h82, 0);
    expect_byte(8'h11, 1);
    expect_byte(8'h83, 10);
    expect_byte(8'h33, 1);
    enqueue(2, 8'h11, 1'b0);
    enqueue(3, 8'h33, 1'b1);
    drive();
    drain(60);
    check_eq("t4_abort_cnt", 32'(abort_cnt), 32'd1);
    check_eq("t4_abort_delay", 32'(abort_gap), 32'd9);
    check_eq("t4_busy", 32'(busy), 32'd0);

    // Reset mid-payload of requester 9
    allow_mask = (N'(1) << 9) | N'(1);
    abort_cnt  = 0;
    expect_byte(8'h89, 0);
    expect_byte(8'h91, 1);
    enqueue(9, 8'h91, 1'b0);
    enqueue(9, 8'h92, 1'b0);
    enqueue(9, 8'h93, 1'b1);
    drive();
    drain(20);
    check_eq("t5_pre_valid", 32'(tx_valid), 32'd1);
    arst = 1'b1;
    #1;
    check_eq("t5_rst_valid", 32'(tx_valid), 32'd0);
    check_eq("t5_rst_ready", 32'(req_ready), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_data", 32'(tx_data), 32'd0);
    enqueue(0, 8'h01, 1'b1);
    expect_byte(8'h80, 0);
    expect_byte(8'h01, 1);
    expect_byte(8'h89, 2);
    expect_byte(8'h92, 1);
    expect_byte(8'h93, 1);
    step();
    step();
    arst = 1'b0;
    drain(40);
    check_eq("t5_abort_cnt", 32'(abort_cnt), 32'd0);

    // Back-to-back frames keep exactly one idle cycle between them
    allow_mask = (N'(1) << 5) | (N'(1) << 6);
    expect_byte(8'h85, 0);
    expect_byte(8'h51, 1);
    expect_byte(8'h52, 1);
    expect_byte(8'h86, 2);
    expect_byte(8'h61, 1);
    expect_byte(8'h85, 2);
    expect_byte(8'h53, 1);
    enqueue(5, 8'h51, 1'b0);
    enqueue(5, 8'h52, 1'b1);
    enqueue(5, 8'h53, 1'b1);
    enqueue(6, 8'h61, 1'b1);
    drive();
    drain(60);
    check_eq("t6_grant", 32'(grant_idx), 32'd5);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_abort_cnt", 32'(abort_cnt), 32'd0);

    for (int i = 0; i < 3; i++) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_arbiter.md
UART_FRAME_ARBITER -- requirements
Module: uart_frame_arbiter

Interface
REQ-001 SHALL have parameter REQ_COUNT, default 16, number of requesters (legal range 2..128).
REQ-002 SHALL have parameter TIMEOUT, default 1024, stall cycles before a granted frame is aborted (legal range 1..65535).
REQ-003 SHALL define localparam IDX_W = $clog2(REQ_COUNT).
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 arst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_valid_i  in  REQ_COUNT  per-requester byte valid.
REQ-007 req_data_i  in  REQ_COUNT*8  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-008 req_last_i  in  REQ_COUNT  marks the final byte of the requester's frame.
REQ-009 req_ready_o  out  REQ_COUNT  per-requester byte accepted.
REQ-010 tx_valid_o  out  1  byte valid toward the UART transmitter.
REQ-011 tx_data_o  out  8  byte toward the UART transmitter.
REQ-012 tx_ready_i  in  1  UART transmitter accepts the byte.
REQ-013 busy_o  out  1  high whenever state is not IDLE.
REQ-014 grant_idx_o  out  IDX_W  index of the current or most recent grant.
REQ-015 abort_o  out  1  one-cycle pulse on frame timeout.

Function
REQ-016 SHALL implement three states: IDLE, HEADER and PAYLOAD.
REQ-017 Handshake SHALL be defined as valid AND ready sampled high on the same rising edge.
REQ-018 IDLE: when any req_valid_i bit is high, SHALL register the winner into grant_idx_o and enter HEADER on the next edge.
- Winner = first asserted index searching upward from (last_grant+1) mod REQ_COUNT, wrapping around.
REQ-019 IDLE: tx_valid_o SHALL be 0 and all req_ready_o bits SHALL be 0.
REQ-020 HEADER: tx_valid_o SHALL be 1, with tx_data_o = 8'h80 | grant_idx_o (zero-extended).
- tx_data_o SHALL be held stable until the handshake, then the block enters PAYLOAD.
- All req_ready_o bits SHALL be 0 in HEADER.
REQ-021 PAYLOAD: combinational pass-through from the granted requester g.
- tx_valid_o = req_valid_i[g]; tx_data_o = req_data_i[g].
- req_ready_o[g] = tx_ready_i; every other req_ready_o bit = 0.
REQ-022 PAYLOAD: a handshake with req_last_i[g] high SHALL set last_grant to g and return to IDLE.
- No new grant SHALL be made in the same cycle; the minimum gap is one IDLE cycle between frames.
REQ-023 PAYLOAD stall counter:
- Increments on each cycle with req_valid_i[g] low.
- Clears on each payload handshake and on entry to PAYLOAD.
- Width is $clog2(TIMEOUT+1).
REQ-024 When the stall counter reaches TIMEOUT, SHALL, on that edge:
- return to IDLE;
- set last_grant to g;
- pulse abort_o high for exactly one cycle.
- No trailer byte is emitted.
REQ-025 tx_ready_i low SHALL NOT advance the stall counter while req_valid_i[g] is high.
REQ-026 Deasserting req_valid_i in HEADER SHALL NOT cancel the grant; the header is still sent.
REQ-027 req_valid_i and req_last_i of non-granted requesters SHALL be ignored outside IDLE.
REQ-028 A zero-payload frame is impossible: a frame always carries at least one payload byte, which ends with last.

Reset
REQ-029 While arst_i is high, immediately and independently of clk_i, the block SHALL hold:
- state = IDLE; tx_valid_o = 0; tx_data_o = 0; req_ready_o = 0; busy_o = 0; abort_o = 0;
- grant_idx_o = 0; last_grant = REQ_COUNT-1; stall counter = 0.
REQ-030 Reset asserted mid-frame SHALL truncate the frame without an abort_o pulse.
- After reset release, requester 0 has highest priority.

Verification
REQ-031 Req 3 sends AA, BB (last on BB), tx_ready_i held 1 -> tx bytes 83, AA, BB; only req_ready_o[3] ever high; busy_o falls after BB.
REQ-032 All 16 requesters hold one-byte frames continuously after reset -> header sequence 80, 81, ..., 8F, then 80 again.
REQ-033 tx_ready_i low for 5 cycles during HEADER for req 7 -> tx_data_o stable at 87, req_ready_o all 0, no payload consumed.
REQ-034 TIMEOUT=8; req 2 sends header and one non-last byte, then valid low for 8 cycles -> one abort_o pulse, busy_o 0, next grant is req 3 if pending.
REQ-035 arst_i pulsed during PAYLOAD of req 9 -> tx_valid_o and req_ready_o go to 0 before the next clock edge; after release with reqs 0 and 9 valid, header 80 is sent first.
REQ-036 Req 5 finishes a frame while reqs 5 and 6 are valid -> exactly one IDLE cycle, then header 86.
